// File: rtl/spi_dual_mode_core.sv
// Byte-wide SPI controller, master or slave, configured through a single
// control register (SPCR) on a strobe/write-enable register bus.
module spi_dual_mode_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [1:0]  SPCR_ADR   = 2'b00
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  inout  wire                   mosi,
  inout  wire                   miso,
  inout  wire                   sck,
  input  logic                  ssn_i,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data
);

  typedef enum logic {M_IDLE, M_RUN} mstate_e;

  mstate_e               state_q;
  logic [DATA_WIDTH-1:0] spcr_q;
  logic [2:0]            sck_s_q;
  logic [1:0]            mosi_s_q, ssn_s_q;
  logic [DATA_WIDTH-1:0] hold_q, sr_q, rx_sr_q, rx_data_q;
  logic                  pend_q, have_q, rx_valid_q, sck_q;
  logic [2:0]            cnt_q;
  logic [3:0]            ecnt_q;
  logic [7:0]            div_q;

  logic spe, mstr, cpol, cpha, wr, slv_act, m_tick, edge_ev, new_lvl, rx_bit;
  logic lead, trail, smp, sft, load;
  logic [7:0] half_m1;
  logic mosi_oe, miso_oe, sck_oe;
  logic spcr_rsvd_unused;

  assign spe  = spcr_q[7];
  assign mstr = spcr_q[6];
  assign cpol = spcr_q[4];
  assign cpha = spcr_q[3];
  assign spcr_rsvd_unused = spcr_q[5];
  assign wr   = stb_i & we_i & (addr_i == SPCR_ADR);

  // Master events come from the locally generated sck and sample miso straight
  // from the pad; a synchronizer there would lag a 2-cycle sck period.
  always_comb begin
    slv_act = spe & ~mstr & ~ssn_s_q[1];
    half_m1 = (8'd1 << spcr_q[2:0]) - 8'd1;
    m_tick  = spe & mstr & (state_q == M_RUN) & (div_q == half_m1);
    if (mstr) begin
      edge_ev = m_tick;
      new_lvl = ~sck_q;
      rx_bit  = miso;
    end else begin
      edge_ev = slv_act & (sck_s_q[1] != sck_s_q[2]);
      new_lvl = sck_s_q[1];
      rx_bit  = mosi_s_q[1];
    end
    lead  = edge_ev & (new_lvl != cpol);
    trail = edge_ev & (new_lvl == cpol);
    smp   = cpha ? trail : lead;
    sft   = cpha ? lead : trail;
    load  = spe & (cnt_q == 3'd0) & pend_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= M_IDLE;
      spcr_q     <= '0;
      sck_s_q    <= '0;
      mosi_s_q   <= '0;
      ssn_s_q    <= '1;
      hold_q     <= '0;
      sr_q       <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      pend_q     <= 1'b0;
      have_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      cnt_q      <= '0;
      ecnt_q     <= '0;
      div_q      <= '0;
    end else begin
      sck_s_q    <= {sck_s_q[1:0], sck};
      mosi_s_q   <= {mosi_s_q[0], mosi};
      ssn_s_q    <= {ssn_s_q[0], ssn_i};
      rx_valid_q <= 1'b0;
      if (wr) begin
        spcr_q  <= data_i;
        cnt_q   <= '0;
        state_q <= M_IDLE;
        sck_q   <= data_i[4];
        div_q   <= '0;
        ecnt_q  <= '0;
        have_q  <= 1'b0;
      end else if (!spe) begin
        cnt_q   <= '0;
        state_q <= M_IDLE;
        sck_q   <= cpol;
        div_q   <= '0;
        ecnt_q  <= '0;
        have_q  <= 1'b0;
      end else begin
        if (load) begin
          sr_q   <= hold_q;
          pend_q <= 1'b0;
          if (mstr) have_q <= 1'b1;
        end else if (sft && cnt_q != 3'd0) begin
          sr_q <= {sr_q[DATA_WIDTH-2:0], 1'b0};
        end
        if (smp) begin
          rx_sr_q <= {rx_sr_q[DATA_WIDTH-2:0], rx_bit};
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_q  <= {rx_sr_q[DATA_WIDTH-2:0], rx_bit};
            rx_valid_q <= 1'b1;
          end
        end
        if (!mstr && ssn_s_q[1]) cnt_q <= '0;
        if (mstr) begin
          unique case (state_q)
            M_IDLE: begin
              sck_q  <= cpol;
              div_q  <= '0;
              ecnt_q <= '0;
              if (have_q) begin
                state_q <= M_RUN;
                have_q  <= 1'b0;
              end
            end
            M_RUN: begin
              if (m_tick) begin
                div_q  <= '0;
                sck_q  <= ~sck_q;
                ecnt_q <= ecnt_q + 4'd1;
                // 16th edge: continue seamlessly if a byte was loaded meanwhile
                if (ecnt_q == 4'd15) begin
                  if (have_q || load) have_q <= 1'b0;
                  else state_q <= M_IDLE;
                end
              end else begin
                div_q <= div_q + 8'd1;
              end
            end
            default: state_q <= M_IDLE;
          endcase
        end
      end
      if (tx_valid) begin
        hold_q <= tx_data;
        pend_q <= 1'b1;
      end
    end
  end

  assign mosi_oe  = spe & mstr;
  assign sck_oe   = spe & mstr;
  assign miso_oe  = slv_act;
  assign mosi     = mosi_oe ? sr_q[DATA_WIDTH-1] : 1'bz;
  assign sck      = sck_oe  ? sck_q : 1'bz;
  assign miso     = miso_oe ? sr_q[DATA_WIDTH-1] : 1'bz;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_dual_mode_core.sv
// Directed bench for spi_dual_mode_core: slave modes 0/3, ssn abort,
// master loopback and SPCR-rewrite abort.
`timescale 1ns/1ps
module tb_spi_dual_mode_core;

  logic       clk = 1'b0;
  logic       rstn;
  logic       stb, we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       ssn;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  wire        mosi, miso, sck;

  logic tb_sck, tb_sck_oe, tb_mosi, tb_mosi_oe, loop_en;
  assign sck  = tb_sck_oe  ? tb_sck  : 1'bz;
  assign mosi = tb_mosi_oe ? tb_mosi : 1'bz;
  assign miso = loop_en    ? mosi    : 1'bz;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned rx_cnt = 0;
  int unsigned rises  = 0;
  logic [7:0]  mcap;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  spi_dual_mode_core #(.DATA_WIDTH(8), .SPCR_ADR(2'b00)) dut (
    .clk_i(clk), .rstn_i(rstn), .stb_i(stb), .we_i(we), .addr_i(addr),
    .data_i(wdata), .mosi(mosi), .miso(miso), .sck(sck), .ssn_i(ssn),
    .tx_valid(tx_valid), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always @(posedge clk) if (rx_valid) rx_cnt <= rx_cnt + 1;
  always @(posedge sck) if (mon_en) begin
    rises <= rises + 1;
    mcap  <= {mcap[6:0], mosi};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [7:0] d);
    @(negedge clk); stb = 1'b1; we = 1'b1; addr = 2'b00; wdata = d;
    @(negedge clk); stb = 1'b0; we = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] d);
    @(negedge clk); tx_valid = 1'b1; tx_data = d;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Plays the external master for nbits bits, MSB first; captures miso per bit.
  task automatic slv_bits(input logic [7:0] mo, input int nbits, input logic cpol,
                          input logic cpha, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (cpha) tb_sck = ~cpol;
      tb_mosi = mo[i];
      #80;
      mi = {mi[6:0], miso};
      tb_sck = cpha ? cpol : ~cpol;
      #80;
      if (!cpha) tb_sck = cpol;
    end
  endtask

  logic [7:0]  got;
  int unsigned base;

  initial begin
    rstn = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    ssn = 1'b1; tx_valid = 1'b0; tx_data = '0;
    tb_sck = 1'b0; tb_sck_oe = 1'b1; tb_mosi = 1'b0; tb_mosi_oe = 1'b1; loop_en = 1'b0;
    wait_clk(3);
    chk("rst_spcr", dut.spcr_q, 8'h00);
    chk("rst_rxv", rx_valid, 1'b0);
    chk("rst_rxd", rx_data, 8'h00);
    chk("rst_oe", {dut.mosi_oe, dut.miso_oe, dut.sck_oe}, 3'b000);
    rstn = 1'b1;
    wait_clk(2);

    reg_wr(8'h83);
    wait_clk(4);
    chk("spcr_83", dut.spcr_q, 8'h83);
    chk("miso_z_ssn1", dut.miso_oe, 1'b0);
    chk("rxv_idle", rx_valid, 1'b0);

    // Slave mode 0, 16 bytes
    send_tx(8'h01);
    ssn = 1'b0;
    wait_clk(5);
    for (int k = 0; k < 16; k++) begin
      slv_bits(8'(15 - k), 8, 1'b0, 1'b0, got);
      chk("m0_miso", got, 8'(k + 1));
      chk("m0_rxd", rx_data, 8'(15 - k));
      if (k < 15) send_tx(8'(k + 2));
    end
    chk("m0_rxcnt", rx_cnt, 16);

    // Slave mode 3
    ssn = 1'b1;
    wait_clk(5);
    tb_sck = 1'b1;
    reg_wr(8'h9B);
    send_tx(8'hA5);
    base = rx_cnt;
    ssn = 1'b0;
    wait_clk(5);
    slv_bits(8'hA5, 8, 1'b1, 1'b1, got);
    chk("m3_miso", got, 8'hA5);
    chk("m3_rxd", rx_data, 8'hA5);
    chk("m3_rxcnt", rx_cnt - base, 1);

    // ssn abort mid-byte
    ssn = 1'b1;
    wait_clk(5);
    tb_sck = 1'b0;
    reg_wr(8'h83);
    wait_clk(5);
    base = rx_cnt;
    ssn = 1'b0;
    wait_clk(5);
    slv_bits(8'hFF, 4, 1'b0, 1'b0, got);
    ssn = 1'b1;
    wait_clk(10);
    chk("ssn_abort_norxv", rx_cnt - base, 0);
    ssn = 1'b0;
    wait_clk(5);
    slv_bits(8'h3C, 8, 1'b0, 1'b0, got);
    chk("ssn_rxcnt", rx_cnt - base, 1);
    chk("ssn_rxd", rx_data, 8'h3C);

    // Master, SPR=0, loopback
    ssn = 1'b1;
    wait_clk(5);
    tb_sck_oe = 1'b0; tb_mosi_oe = 1'b0; loop_en = 1'b1;
    reg_wr(8'hC0);
    wait_clk(3);
    rises = 0; mcap = '0; mon_en = 1'b1;
    base = rx_cnt;
    send_tx(8'h96);
    for (int i = 0; i < 300 && rx_cnt == base; i++) @(negedge clk);
    wait_clk(10);
    mon_en = 1'b0;
    chk("mst_rxcnt", rx_cnt - base, 1);
    chk("mst_rises", rises, 8);
    chk("mst_mosi", mcap, 8'h96);
    chk("mst_rxd", rx_data, 8'h96);
    chk("mst_sck_idle", sck, 1'b0);
    chk("mst_drv", {dut.sck_oe, dut.mosi_oe, dut.miso_oe}, 3'b110);

    // SPCR rewrite mid-byte
    loop_en = 1'b0;
    reg_wr(8'h83);
    tb_sck = 1'b0; tb_sck_oe = 1'b1; tb_mosi_oe = 1'b1;
    wait_clk(5);
    base = rx_cnt;
    ssn = 1'b0;
    wait_clk(5);
    slv_bits(8'hFF, 3, 1'b0, 1'b0, got);
    reg_wr(8'h83);
    wait_clk(5);
    chk("wr_abort_norxv", rx_cnt - base, 0);
    slv_bits(8'h5A, 8, 1'b0, 1'b0, got);
    chk("wr_rxcnt", rx_cnt - base, 1);
    chk("wr_rxd", rx_data, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
